// File: rtl/ps2_key_arbiter.sv
// ps2_key_arbiter
//   Fully synchronous PS/2 keyboard receiver and key arbiter for the TankWar
//   input path. kclk/kdata are synchronized and kclk is glitch filtered;
//   11-bit frames are checked for start/parity/stop and a watchdog abandons
//   stalled frames. Accepted bytes drive the make/break/extended decoder,
//   which tracks held keys per player and resolves directions to one-hot.
//
// Ports
//   clk_50m       system clock
//   rst           synchronous active-high reset
//   kclk, kdata   raw asynchronous PS/2 clock and data
//   player1_btns  {fire, right, left, down, up} for tank 1
//   player2_btns  {fire, right, left, down, up} for tank 2
//   code_valid    one-cycle pulse per accepted frame
//   code          last accepted scancode byte
//   frame_err     one-cycle pulse on start/parity/stop/timeout error
module ps2_key_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic [4:0] player1_btns,
    output logic [4:0] player2_btns,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Input conditioning
    logic [1:0]    r_kclk_s;
    logic [1:0]    r_kdata_s;
    logic [FW-1:0] r_filt_cnt;
    logic          r_kclk_f;
    logic          r_kclk_prev;
    logic          w_fall;
    logic          w_kdata;

    // Filtered level idles high after reset so reset itself never looks like a fall.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_kclk_s    <= '1;
            r_kdata_s   <= '1;
            r_filt_cnt  <= '0;
            r_kclk_f    <= 1'b1;
            r_kclk_prev <= 1'b1;
        end else begin
            r_kclk_s    <= {r_kclk_s[0], kclk};
            r_kdata_s   <= {r_kdata_s[0], kdata};
            r_kclk_prev <= r_kclk_f;
            if (r_kclk_s[1] == r_kclk_f) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_kclk_f   <= r_kclk_s[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall  = r_kclk_prev & ~r_kclk_f;
    assign w_kdata = r_kdata_s[1];

    // Frame FSM
    state_t        r_state, w_state_nxt;
    logic [2:0]    r_cnt, w_cnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_par_ok, w_par_ok_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          w_accept, w_err;
    logic          r_code_valid, r_frame_err;
    logic [7:0]    r_code;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_par_ok     <= 1'b0;
            r_timer      <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_code       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_par_ok     <= w_par_ok_nxt;
            r_timer      <= w_timer_nxt;
            r_code_valid <= w_accept;
            r_frame_err  <= w_err;
            if (w_accept) r_code <= r_shift;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_par_ok_nxt = r_par_ok;
        w_timer_nxt  = '0;
        w_accept     = 1'b0;
        w_err        = 1'b0;
        if (r_state != S_IDLE && !w_fall) w_timer_nxt = r_timer + 1'b1;
        if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_kdata) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_DATA: begin
                    w_shift_nxt = {w_kdata, r_shift[7:1]};
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (r_cnt == 3'd7) w_state_nxt = S_PARITY;
                end
                S_PARITY: begin
                    w_par_ok_nxt = ^{r_shift, w_kdata};
                    w_state_nxt  = S_STOP;
                end
                S_STOP: begin
                    if (r_par_ok && w_kdata) w_accept = 1'b1;
                    else                     w_err    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (r_state != S_IDLE && r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    // Decoder and per-player arbitration
    logic       r_brk, r_ext;
    logic [4:0] r_p1_held, r_p2_held;
    logic [3:0] r_p1_dir, r_p2_dir;
    logic       w_p1_hit, w_p2_hit;
    logic [2:0] w_p1_idx, w_p2_idx;

    // Index 0..3 = up, down, left, right; 4 = fire (does not touch direction).
    function automatic logic [3:0] f_next_dir(input logic [4:0] held, input logic [3:0] dir,
                                              input logic [2:0] idx, input logic make);
        logic [4:0] remain;
        logic [3:0] res;
        res    = dir;
        remain = held & ~(5'b00001 << idx);
        if (idx != 3'd4) begin
            if (make) begin
                if (!held[idx]) res = 4'b0001 << idx[1:0];
            end else if (dir[idx[1:0]]) begin
                if      (remain[0]) res = 4'b0001;
                else if (remain[1]) res = 4'b0010;
                else if (remain[2]) res = 4'b0100;
                else if (remain[3]) res = 4'b1000;
                else                res = 4'b0000;
            end
        end
        return res;
    endfunction

    always_comb begin
        w_p1_hit = 1'b0;
        w_p1_idx = 3'd0;
        w_p2_hit = 1'b0;
        w_p2_idx = 3'd0;
        case (r_code)
            8'h1D: begin w_p1_hit = !r_ext; w_p1_idx = 3'd0; end
            8'h1B: begin w_p1_hit = !r_ext; w_p1_idx = 3'd1; end
            8'h1C: begin w_p1_hit = !r_ext; w_p1_idx = 3'd2; end
            8'h23: begin w_p1_hit = !r_ext; w_p1_idx = 3'd3; end
            8'h29: begin w_p1_hit = !r_ext; w_p1_idx = 3'd4; end
            8'h75: begin w_p2_hit = 1'b1;   w_p2_idx = 3'd0; end
            8'h72: begin w_p2_hit = 1'b1;   w_p2_idx = 3'd1; end
            8'h6B: begin w_p2_hit = 1'b1;   w_p2_idx = 3'd2; end
            8'h74: begin w_p2_hit = 1'b1;   w_p2_idx = 3'd3; end
            8'h70: begin w_p2_hit = !r_ext; w_p2_idx = 3'd4; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_p1_held <= '0;
            r_p2_held <= '0;
            r_p1_dir  <= '0;
            r_p2_dir  <= '0;
        end else if (r_frame_err) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else if (r_code_valid) begin
            if (r_code == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (r_code == 8'hE0) begin
                r_ext <= 1'b1;
            end else begin
                if (w_p1_hit) begin
                    r_p1_held[w_p1_idx] <= !r_brk;
                    r_p1_dir <= f_next_dir(r_p1_held, r_p1_dir, w_p1_idx, !r_brk);
                end
                if (w_p2_hit) begin
                    r_p2_held[w_p2_idx] <= !r_brk;
                    r_p2_dir <= f_next_dir(r_p2_held, r_p2_dir, w_p2_idx, !r_brk);
                end
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end
        end
    end

    assign player1_btns = {r_p1_held[4], r_p1_dir};
    assign player2_btns = {r_p2_held[4], r_p2_dir};
    assign code_valid   = r_code_valid;
    assign code         = r_code;
    assign frame_err    = r_frame_err;

endmodule

// File: doc/ps2_key_arbiter.md
Name: ps2_key_arbiter

Overview:
- Replaces the negedge-kclk keyboard front end with a fully synchronous PS/2 receive controller for the TankWar input path.
- Samples kclk and kdata on clk_50m and frames 11-bit packets with parity and stop checking.
- Sequences the make, break (F0) and extended (E0) prefix protocol, and tracks held keys per player.
- Arbitrates simultaneously held direction keys into a clean one-hot direction plus an independent fire bit for each tank.

Parameters:
- TIMEOUT_CYCLES, 50000, clk_50m cycles without a kclk falling edge before a partial frame is abandoned (1 ms).
- FILTER_LEN, 4, consecutive equal synchronized samples required before the filtered kclk level changes.

Ports:
- clk_50m  input  1  system clock, 50 MHz
- rst  input  1  synchronous, active-high reset
- kclk  input  1  raw PS/2 clock, asynchronous
- kdata  input  1  raw PS/2 data, asynchronous
- player1_btns  output  5  {fire, right, left, down, up}
- player2_btns  output  5  {fire, right, left, down, up}
- code_valid  output  1  one-cycle pulse when a frame is accepted
- code  output  8  last accepted scancode byte
- frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error

Behaviour:
- Clock and reset: one clock, clk_50m. Reset is synchronous and active-high on rst. rst wins over every other event in the same cycle.
- Reset values: all outputs 0, all held bits 0, prefix flags 0, frame FSM in IDLE.
- Input conditioning: kclk and kdata each pass through a 2-FF synchronizer. kclk then passes a FILTER_LEN-sample glitch filter.
  - A fall is filtered kclk going 1 to 0.
  - kdata is sampled on the same cycle the fall is detected.
- Frame FSM, advancing on each fall:
  - IDLE: requires bit = 0 (start bit), otherwise frame_err and stay in IDLE. On a valid start, go to DATA with cnt = 0.
  - DATA: shift 8 bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: the parity bit must make the 9 bits odd-parity. Latch the pass/fail result and go to STOP.
  - STOP: the stop bit must be 1. If parity and stop are both good, pulse code_valid with code = byte. Otherwise pulse frame_err. Return to IDLE.
  - Watchdog: in any non-IDLE state, TIMEOUT_CYCLES cycles with no fall gives frame_err and a return to IDLE.
- Error handling: on any frame_err, discard the byte and clear the break and extended flags.
- code_valid timing: pulses 1 cycle after the stop-bit fall is detected.
- Decoder, acting on each accepted byte:
  - F0: set brk.
  - E0: set ext.
  - Any other byte: look the byte up in the key map. If it matches, set the held bit for a make or clear it for a break (brk = 1). Then clear brk and ext. Unknown bytes only clear the flags.
- Key map:
  - Player 1 accepts non-extended codes only: up 1D, down 1B, left 1C, right 23, fire 29.
  - Player 2 accepts codes with ext = 0 (numpad) or ext = 1 (arrows): up 75, down 72, left 6B, right 74.
  - Player 2 fire is 70 with ext = 0 only.
- Direction arbitration, per player:
  - active_dir is a one-hot register.
  - A make of a direction key that is not already held sets active_dir to that key (last pressed wins).
  - A typematic repeat make of an already-held key leaves active_dir unchanged.
  - A break of the active direction falls back to the highest-priority still-held direction (up > down > left > right), or 0 if none is held.
  - A break of a non-active direction leaves active_dir unchanged.
- Outputs: btns[3:0] = active_dir (never more than one bit set). btns[4] = fire held bit, independent of the directions.
- Update latency: btns update on the cycle after code_valid.

Test Plan:
- Single key: frame 1D, then F0 1D -> player1_btns = 00001 after the first frame, 00000 after the break. code_valid pulses 3 times with code = 1D, F0, 1D.
- Priority and fallback: player 1 make 1C then make 23 -> 01000. Break 23 -> 00100. Break 1C -> 00000. Repeat make 1C while 23 is still held -> stays 01000.
- Parity error: frame 1D with the parity bit flipped -> frame_err pulses, no code_valid, player1_btns stays 00000. A following good F0 still leaves outputs 0.
- Extended and fire: E0 75 -> player2_btns = 00001. Then 70 -> 10001. Then E0 F0 75 -> 10000. E0 29 -> player 1 unchanged.
- Timeout: a start bit plus 3 data bits, then no clock for 50000 cycles -> frame_err pulse, FSM back in IDLE. The next full frame 29 -> player1_btns = 10000.
- Reset: rst asserted mid-frame with keys held -> all outputs 0 on the next cycle. The remaining bits of the interrupted frame yield frame_err or are ignored, and no key is set.
